// File: rtl/writeback_queue_if.sv
// Producer-to-queue write offer: one register write per handshake.
interface writeback_queue_if;
  logic        wbValid;
  logic [4:0]  wbReg;
  logic [31:0] wbData;
  logic        wbReady;

  modport master (output wbValid, output wbReg, output wbData, input wbReady);
  modport slave  (input wbValid, input wbReg, input wbData, output wbReady);
endinterface

// File: rtl/writeback_queue.sv
// Writeback queue: buffers pending register-file writes in a FIFO, drains one
// per unstalled cycle through a registered output stage, and forwards the
// newest pending value for two read ports.
module writeback_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  writeback_queue_if.slave         wb,
  input  logic                     stallIn,
  output logic                     regWrite,
  output logic [4:0]               writeReg,
  output logic [31:0]              writeData,
  input  logic [4:0]               readReg1,
  input  logic [4:0]               readReg2,
  output logic                     fwdHitA,
  output logic                     fwdHitB,
  output logic [31:0]              fwdDataA,
  output logic [31:0]              fwdDataB,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // Storage array; only pointers and count track validity, so it has no reset.
  logic [REG_W-1:0]  ent_reg_q  [DEPTH];
  logic [DATA_W-1:0] ent_data_q [DEPTH];

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              reg_write_q, reg_write_d;
  logic [REG_W-1:0]  write_reg_q, write_reg_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;

  logic wb_ready;
  logic accept;
  logic push;
  logic pop;

  // Slot index at a given age offset from the head, wrapping modulo DEPTH.
  function automatic logic [PTR_W-1:0] slot(input logic [PTR_W-1:0] base, input int off);
    return base + PTR_W'(off);
  endfunction

  // Readiness comes only from registered count: no pass-through when full.
  assign wb_ready   = (count_q < DEPTH_C);
  assign wb.wbReady = wb_ready;

  assign regWrite  = reg_write_q;
  assign writeReg  = write_reg_q;
  assign writeData = write_data_q;
  assign count     = count_q;

  // Next-state: handshake, zero-register discard, pop into output stage.
  always_comb begin
    accept       = wb.wbValid && wb_ready;
    push         = accept && (wb.wbReg != '0);
    pop          = (count_q != '0) && !stallIn;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    reg_write_d  = pop;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    if (push) begin
      tail_d = tail_q + PTR_W'(1);
    end
    if (pop) begin
      head_d       = head_q + PTR_W'(1);
      write_reg_d  = ent_reg_q[head_q];
      write_data_d = ent_data_q[head_q];
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control and output-stage registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end

  // Entry storage written at the tail on every accepted non-zero write.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_reg_q[tail_q]  <= wb.wbReg;
      ent_data_q[tail_q] <= wb.wbData;
    end
  end

  // Forwarding: output stage is lowest priority, then queue entries from
  // oldest to newest so the newest match overrides. The offer on wbData
  // this cycle is deliberately not considered.
  always_comb begin
    fwdHitA  = 1'b0;
    fwdHitB  = 1'b0;
    fwdDataA = '0;
    fwdDataB = '0;
    if (reg_write_q && (readReg1 != '0) && (write_reg_q == readReg1)) begin
      fwdHitA  = 1'b1;
      fwdDataA = write_data_q;
    end
    if (reg_write_q && (readReg2 != '0) && (write_reg_q == readReg2)) begin
      fwdHitB  = 1'b1;
      fwdDataB = write_data_q;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < count_q) begin
        if ((readReg1 != '0) && (ent_reg_q[slot(head_q, i)] == readReg1)) begin
          fwdHitA  = 1'b1;
          fwdDataA = ent_data_q[slot(head_q, i)];
        end
        if ((readReg2 != '0) && (ent_reg_q[slot(head_q, i)] == readReg2)) begin
          fwdHitB  = 1'b1;
          fwdDataB = ent_data_q[slot(head_q, i)];
        end
      end
    end
  end

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue (DEPTH=4).
module tb_writeback_queue;

  logic        clk;
  logic        rst_n;
  logic        stallIn;
  logic        regWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic [4:0]  readReg1;
  logic [4:0]  readReg2;
  logic        fwdHitA;
  logic        fwdHitB;
  logic [31:0] fwdDataA;
  logic [31:0] fwdDataB;
  logic [2:0]  count;

  int checks   = 0;
  int failures = 0;

  writeback_queue_if wb();

  writeback_queue #(.DEPTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wb       (wb),
    .stallIn  (stallIn),
    .regWrite (regWrite),
    .writeReg (writeReg),
    .writeData(writeData),
    .readReg1 (readReg1),
    .readReg2 (readReg2),
    .fwdHitA  (fwdHitA),
    .fwdHitB  (fwdHitB),
    .fwdDataA (fwdDataA),
    .fwdDataB (fwdDataB),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [4:0] r, input logic [31:0] d);
    wb.wbValid = v;
    wb.wbReg   = r;
    wb.wbData  = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [36:0] mq[$];
    logic [36:0] head_e;
    logic        stall_r;
    logic        do_pop;
    logic        exp_ready;
    int          sent;
    int          written;
    int          cyc;

    rst_n    = 1'b0;
    stallIn  = 1'b0;
    readReg1 = 5'd0;
    readReg2 = 5'd0;
    offer(1'b0, 5'd0, 32'd0);
    step();
    step();

    // Reset state
    check("rst_count",     32'(count), 32'd0);
    check("rst_ready",     32'(wb.wbReady), 32'd1);
    check("rst_regwrite",  32'(regWrite), 32'd0);
    check("rst_writereg",  32'(writeReg), 32'd0);
    check("rst_writedata", writeData, 32'd0);
    check("rst_fwdhita",   32'(fwdHitA), 32'd0);
    check("rst_fwdhitb",   32'(fwdHitB), 32'd0);
    rst_n = 1'b1;
    step();

    // Single write r5=DEADBEEF; offered data must not forward yet
    offer(1'b1, 5'd5, 32'hDEADBEEF);
    readReg1 = 5'd5;
    #1;
    check("single_nofwd_offer", 32'(fwdHitA), 32'd0);
    step();
    offer(1'b0, 5'd0, 32'd0);
    check("single_count1",   32'(count), 32'd1);
    check("single_rw_early", 32'(regWrite), 32'd0);
    check("single_fwd_q",    32'(fwdHitA), 32'd1);
    check("single_fwd_qd",   fwdDataA, 32'hDEADBEEF);
    step();
    check("single_rw",       32'(regWrite), 32'd1);
    check("single_reg",      32'(writeReg), 32'd5);
    check("single_data",     writeData, 32'hDEADBEEF);
    check("single_count0",   32'(count), 32'd0);
    check("single_fwd_out",  fwdDataA, 32'hDEADBEEF);
    step();
    check("single_rw_end",   32'(regWrite), 32'd0);
    check("single_reg_hold", 32'(writeReg), 32'd5);
    check("single_fwd_end",  32'(fwdHitA), 32'd0);

    // Zero register write is consumed and discarded
    readReg1 = 5'd0;
    offer(1'b1, 5'd0, 32'hFFFFFFFF);
    #1;
    check("zero_ready", 32'(wb.wbReady), 32'd1);
    step();
    offer(1'b0, 5'd0, 32'd0);
    check("zero_count", 32'(count), 32'd0);
    check("zero_fwd",   32'(fwdHitA), 32'd0);
    check("zero_fwdd",  fwdDataA, 32'd0);
    step();
    check("zero_rw",    32'(regWrite), 32'd0);

    // Forwarding priority: r7=0x11 then r7=0x22
    stallIn = 1'b1;
    offer(1'b1, 5'd7, 32'h11);
    step();
    offer(1'b1, 5'd7, 32'h22);
    step();
    offer(1'b0, 5'd0, 32'd0);
    readReg1 = 5'd7;
    readReg2 = 5'd0;
    #1;
    check("fwd_count", 32'(count), 32'd2);
    check("fwd_hita",  32'(fwdHitA), 32'd1);
    check("fwd_dataa", fwdDataA, 32'h22);
    check("fwd_hitb0", 32'(fwdHitB), 32'd0);
    check("fwd_datab0", fwdDataB, 32'd0);
    readReg2 = 5'd7;
    #1;
    check("fwd_hitb",  32'(fwdHitB), 32'd1);
    check("fwd_datab", fwdDataB, 32'h22);
    stallIn = 1'b0;
    step();
    check("fwd_drain1_data", writeData, 32'h11);
    check("fwd_drain1_fwd",  fwdDataA, 32'h22);
    step();
    check("fwd_drain2_data", writeData, 32'h22);
    check("fwd_drain2_cnt",  32'(count), 32'd0);
    check("fwd_drain2_fwd",  fwdDataA, 32'h22);
    check("fwd_drain2_hit",  32'(fwdHitA), 32'd1);
    step();
    check("fwd_drain3_rw",   32'(regWrite), 32'd0);
    readReg1 = 5'd0;
    readReg2 = 5'd0;

    // Fill with stall, then drain in order; r5 enters once space frees
    stallIn = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      offer(1'b1, 5'(i), 32'h100 + 32'(i));
      #1;
      check($sformatf("fill_ready_%0d", i), 32'(wb.wbReady), (i <= 4) ? 32'd1 : 32'd0);
      step();
    end
    check("fill_count", 32'(count), 32'd4);
    check("fill_full",  32'(wb.wbReady), 32'd0);
    stallIn = 1'b0;
    step();
    check("fill_d1_reg", 32'(writeReg), 32'd1);
    check("fill_d1_rw",  32'(regWrite), 32'd1);
    check("fill_d1_cnt", 32'(count), 32'd3);
    step();
    offer(1'b0, 5'd0, 32'd0);
    check("fill_d2_reg", 32'(writeReg), 32'd2);
    check("fill_d2_cnt", 32'(count), 32'd3);
    for (int i = 3; i <= 5; i++) begin
      step();
      check($sformatf("fill_d%0d_rw", i),   32'(regWrite), 32'd1);
      check($sformatf("fill_d%0d_reg", i),  32'(writeReg), 32'(i));
      check($sformatf("fill_d%0d_data", i), writeData, 32'h100 + 32'(i));
      check($sformatf("fill_d%0d_cnt", i),  32'(count), 32'(5 - i));
    end
    step();
    check("fill_end_rw", 32'(regWrite), 32'd0);

    // Reset mid-drain
    stallIn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      offer(1'b1, 5'(10 + i), 32'hA0 + 32'(i));
      step();
    end
    offer(1'b0, 5'd0, 32'd0);
    stallIn = 1'b0;
    step();
    check("rstmid_rw_pre",  32'(regWrite), 32'd1);
    check("rstmid_cnt_pre", 32'(count), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_rw",    32'(regWrite), 32'd0);
    check("rstmid_cnt",   32'(count), 32'd0);
    check("rstmid_reg",   32'(writeReg), 32'd0);
    check("rstmid_data",  writeData, 32'd0);
    check("rstmid_ready", 32'(wb.wbReady), 32'd1);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("rstmid_after_rw_%0d", i), 32'(regWrite), 32'd0);
    end

    // Wrap: 10 writes with random stall, scoreboard on drain order
    sent    = 0;
    written = 0;
    cyc     = 0;
    while ((sent < 10 || mq.size() != 0) && cyc < 300) begin
      stall_r = 1'($urandom_range(0, 1));
      stallIn = stall_r;
      if (sent < 10) offer(1'b1, 5'(sent + 1), $urandom);
      else           offer(1'b0, 5'd0, 32'd0);
      #1;
      exp_ready = (mq.size() < 4);
      check("wrap_ready", 32'(wb.wbReady), 32'(exp_ready));
      do_pop = (mq.size() > 0) && !stall_r;
      if (do_pop) head_e = mq.pop_front();
      if (wb.wbValid && exp_ready) begin
        mq.push_back({wb.wbReg, wb.wbData});
        sent++;
      end
      step();
      check("wrap_rw", 32'(regWrite), 32'(do_pop));
      if (do_pop) begin
        written++;
        check("wrap_reg",  32'(writeReg), 32'(head_e[36:32]));
        check("wrap_data", writeData, head_e[31:0]);
      end
      check("wrap_count", 32'(count), 32'(mq.size()));
      cyc++;
    end
    offer(1'b0, 5'd0, 32'd0);
    stallIn = 1'b0;
    check("wrap_bound",   32'(cyc < 300), 32'd1);
    check("wrap_written", 32'(written), 32'd10);
    step();
    check("wrap_idle_rw", 32'(regWrite), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 Parameter: DEPTH, 4, number of pending-write entries; power of two, 2..16.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 wbValid  in  1  producer offers one register write this cycle.
REQ-005 wbReg  in  5  destination register number of offered write.
REQ-006 wbData  in  32  data of offered write.
REQ-007 wbReady  out  1  queue can accept the offered write this cycle.
REQ-008 stallIn  in  1  register-file write port unavailable this cycle; no drain.
REQ-009 regWrite  out  1  write strobe to register file, registered.
REQ-010 writeReg  out  5  register number to write, registered.
REQ-011 writeData  out  32  data to write, registered.
REQ-012 readReg1, readReg2  in  5 each  register numbers currently being read from the register file.
REQ-013 fwdHitA, fwdHitB  out  1 each  a pending write targets readReg1 / readReg2.
REQ-014 fwdDataA, fwdDataB  out  32 each  newest pending data for readReg1 / readReg2.
REQ-015 count  out  $clog2(DEPTH)+1  number of entries held in the queue, excluding the output stage.

Function
REQ-016 wbReady SHALL equal (count < DEPTH), derived only from registered state; no pass-through when full, even if a pop occurs in the same cycle.
REQ-017 A handshake SHALL complete when wbValid && wbReady at a rising edge.
REQ-018 A completed handshake with wbReg == 0 SHALL be consumed and discarded: no entry, count unchanged.
REQ-019 A completed handshake with wbReg != 0 SHALL append {wbReg, wbData} at the tail; entries drain in strict FIFO order.
REQ-020 At each edge with count > 0 and stallIn == 0, the head SHALL be popped into the output stage: regWrite=1, writeReg/writeData = head fields on the next cycle.
REQ-021 At each edge with count == 0 or stallIn == 1, regWrite SHALL be 0 on the next cycle; writeReg/writeData SHALL hold their previous values.
REQ-022 regWrite SHALL be high for exactly one cycle per enqueued entry; each write appears on the register-file port exactly once.
REQ-023 Simultaneous push and pop SHALL leave count unchanged; push only: +1; pop only: -1.
REQ-024 Head and tail pointers SHALL wrap modulo DEPTH.
REQ-025 Latency: a write accepted at edge N into an empty, unstalled queue SHALL show regWrite=1 during cycle N+1..N+2, i.e. it is committed by the register file at edge N+2.
REQ-026 fwdHitA SHALL be 1 when readReg1 != 0 and it matches any valid queue entry or the output stage while regWrite=1; fwdHitB likewise for readReg2.
REQ-027 Forwarding priority SHALL be newest queue entry first, then older entries, then the output stage; fwdData carries the winning entry's data.
REQ-028 With no hit, fwdHit SHALL be 0 and fwdData SHALL be 0.
REQ-029 Forwarding outputs SHALL be combinational from registered state and readReg inputs; the write being offered on wbData in the same cycle SHALL NOT forward.

Reset
REQ-030 rst_n low SHALL immediately, without a clock, clear pointers, count=0, regWrite=0, writeReg=0, writeData=0.
REQ-031 During and after reset, wbReady SHALL be 1, and fwdHitA/fwdHitB SHALL be 0.
REQ-032 Reset asserted mid-operation SHALL discard all pending entries and the output stage; none SHALL be written after release.
REQ-033 Queue contents need not be cleared; only the valid-tracking state is reset.

Verification
REQ-034 Single write: wbReg=5, wbData=0xDEADBEEF accepted at edge 1, stallIn=0 -> regWrite=1, writeReg=5, writeData=0xDEADBEEF for exactly one cycle after edge 2.
REQ-035 Fill: stallIn=1, offer 5 writes to r1..r5 with DEPTH=4 -> first 4 accepted; count=4; wbReady=0; release stall -> r1..r4 written in order on 4 consecutive cycles; r5 accepted once count=3.
REQ-036 Forwarding: queue holds r7=0x11 then r7=0x22, with readReg1=7 -> fwdHitA=1, fwdDataA=0x22; readReg2=0 -> fwdHitB=0, fwdDataB=0.
REQ-037 Zero register: accepted write with wbReg=0, wbData=0xFFFFFFFF -> count stays 0; regWrite never asserts; no forward for readReg1=0.
REQ-038 Reset mid-drain: 3 entries pending, regWrite=1; assert rst_n=0 between edges -> regWrite=0 and count=0 immediately; after release no regWrite pulse occurs.
REQ-039 Wrap: with DEPTH=4, 10 writes are interleaved with random stallIn -> the write sequence on writeReg/writeData SHALL match the accepted order exactly.
